// File: rtl/viu_tx_arbiter_pkg.sv
// VIU shared definitions: the 14-bit route word layout used by the TX arbiter
// and the VLAN tag inserter, plus the arbiter state encoding.
package viu_tx_arbiter_pkg;

    localparam int ROUTE_W             = 14;
    localparam int DST_ROUTE_W         = 6;
    localparam int ROUTE_SRC_NODE_MSB  = 13;
    localparam int ROUTE_SRC_NODE_LSB  = 12;
    localparam int ROUTE_SRC_VFPGA_MSB = 11;
    localparam int ROUTE_SRC_VFPGA_LSB = 8;
    localparam int ROUTE_DST_NODE_MSB  = 7;
    localparam int ROUTE_DST_NODE_LSB  = 6;
    localparam int ROUTE_DST_VFPGA_MSB = 5;
    localparam int ROUTE_DST_VFPGA_LSB = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } arb_state_t;

    // Assemble a route word; dst is {dst_node[5:4], dst_vfpga[3:0]}, bits [1:0] stay zero.
    function automatic logic [ROUTE_W-1:0] make_route(input logic [1:0] node,
                                                      input logic [3:0] src,
                                                      input logic [DST_ROUTE_W-1:0] dst);
        logic [ROUTE_W-1:0] r;
        r = '0;
        r[ROUTE_SRC_NODE_MSB:ROUTE_SRC_NODE_LSB]   = node;
        r[ROUTE_SRC_VFPGA_MSB:ROUTE_SRC_VFPGA_LSB] = src;
        r[ROUTE_DST_NODE_MSB:ROUTE_DST_NODE_LSB]   = dst[5:4];
        r[ROUTE_DST_VFPGA_MSB:ROUTE_DST_VFPGA_LSB] = dst[3:0];
        return r;
    endfunction

endpackage

// File: rtl/viu_rr_pick.sv
// Round-robin find-first: first set request scanning upward from rr_ptr+1,
// wrapping modulo N_SRC, so the source at rr_ptr itself is checked last.
module viu_rr_pick #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [3:0]       rr_ptr,
    output logic [3:0]       pick_idx,
    output logic             pick_valid
);

    // Rotated priority scan; the first hit wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % N_SRC;
            for (int j = 0; j < N_SRC; j++) begin
                if (!pick_valid && (j == idx) && req[j]) begin
                    pick_valid = 1'b1;
                    pick_idx   = 4'(j);
                end
            end
        end
    end

endmodule

// File: rtl/viu_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the VIU TX VLAN tagger.
// One source owns the shared stream from grant until its tlast handshake;
// the route word is latched at grant with the source identity forced from
// NODE_ID and the grant index.
module viu_tx_arbiter
    import viu_tx_arbiter_pkg::*;
#(
    parameter int         N_SRC      = 4,
    parameter int         DATA_WIDTH = 512,
    parameter logic [1:0] NODE_ID    = 2'd0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_SRC*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [N_SRC*DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [N_SRC-1:0]             s_axis_tlast,
    input  logic [N_SRC-1:0]             s_axis_tvalid,
    output logic [N_SRC-1:0]             s_axis_tready,
    input  logic [N_SRC*6-1:0]           s_dst_route,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [ROUTE_W-1:0]           route_out,
    output logic [3:0]                   grant_id,
    output logic                         busy
);

    localparam int KW = DATA_WIDTH / 8;

    arb_state_t             state;
    logic [3:0]             rr_ptr;
    logic [3:0]             pick_idx;
    logic                   pick_valid;
    logic [DST_ROUTE_W-1:0] pick_dst;

    viu_rr_pick #(.N_SRC(N_SRC)) u_pick (
        .req        (s_axis_tvalid),
        .rr_ptr     (rr_ptr),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // Destination field of the source about to be granted.
    always_comb begin
        pick_dst = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pick_idx == 4'(i)) begin
                pick_dst = s_dst_route[i*DST_ROUTE_W +: DST_ROUTE_W];
            end
        end
    end

    // Zero-latency stream mux; everything is quiet outside a locked packet.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (state == ST_PKT) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (grant_id == 4'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_axis_tkeep     = s_axis_tkeep[i*KW +: KW];
                    m_axis_tlast     = s_axis_tlast[i];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    // Grant/release FSM; rr_ptr starts at N_SRC-1 so source 0 wins first.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            rr_ptr    <= 4'(N_SRC - 1);
            grant_id  <= '0;
            route_out <= make_route(NODE_ID, 4'd0, '0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id  <= pick_idx;
                        route_out <= make_route(NODE_ID, pick_idx, pick_dst);
                        state     <= ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        rr_ptr <= grant_id;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_PKT);

endmodule

// File: doc/viu_tx_arbiter.md
# viu_tx_arbiter

Packet-granular round-robin arbiter that shares the single VIU TX VLAN-tagging datapath between `N_SRC` vFPGA transmit streams. It sits between the per-vFPGA TX streams and the VLAN tag inserter. It grants one source per packet, muxes that source's AXI-Stream onto the shared output, and drives the 14-bit route word consumed by the tagger. The route word is latched at grant and held stable for the whole packet. The source-identity fields of the route word are forced from the local node ID and the grant index, so a vFPGA cannot spoof its source identity.

## Interface
Parameters:
- `N_SRC`, 4: number of vFPGA TX sources; legal range 1..16.
- `DATA_WIDTH`, 512: AXI-Stream data width in bits.
- `NODE_ID`, 2'd0: local physical node ID, 2 bits, inserted into route[13:12].

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  N_SRC*DATA_WIDTH  per-source data; source i occupies slice i.
- `s_axis_tkeep`  in  N_SRC*DATA_WIDTH/8  per-source byte enables.
- `s_axis_tlast`  in  N_SRC  per-source end of packet.
- `s_axis_tvalid`  in  N_SRC  per-source valid.
- `s_axis_tready`  out  N_SRC  per-source ready.
- `s_dst_route`  in  N_SRC*6  per-source destination {dst_node[5:4], dst_vfpga[3:0]}.
- `m_axis_tdata`  out  DATA_WIDTH  shared output data, to the tagger.
- `m_axis_tkeep`  out  DATA_WIDTH/8  shared output byte enables.
- `m_axis_tlast`  out  1  shared output end of packet.
- `m_axis_tvalid`  out  1  shared output valid.
- `m_axis_tready`  in  1  shared output ready.
- `route_out`  out  14  {NODE_ID, grant[3:0], dst_node, dst_vfpga, 2'b00}.
- `grant_id`  out  4  index of the current or last granted source.
- `busy`  out  1  high while a packet is locked (state ST_PKT).

## Operation
- The FSM has two states: ST_IDLE and ST_PKT.
- ST_IDLE:
  - All `s_axis_tready` = 0 and `m_axis_tvalid` = 0.
  - If any `s_axis_tvalid[i]` = 1, select the first valid source scanning from `rr_ptr+1` upward, modulo N_SRC.
  - On that edge, register `grant_id`, latch `route_out` from that source's `s_dst_route`, and go to ST_PKT.
- ST_PKT:
  - Combinational mux: `m_axis_{tdata,tkeep,tlast,tvalid}` = the granted source's signals.
  - `s_axis_tready[grant]` = `m_axis_tready`; all other readies = 0.
  - On an output handshake with `tlast` = 1: set `rr_ptr` <= grant and return to ST_IDLE.
- `route_out` and `grant_id` hold their value in ST_IDLE until the next grant.
- Changes on `s_dst_route` after the grant edge are ignored until the next grant.
- Source identity route[11:8] = grant index, zero-extended to 4 bits. Route bits [1:0] are always 0.

## Timing
- Reset values:
  - state = ST_IDLE
  - `rr_ptr` = N_SRC-1, so source 0 has first priority
  - `grant_id` = 0
  - `route_out` = {NODE_ID, 12'h000}
  - `busy` = 0
  - all `s_axis_tready` = 0
  - `m_axis_tvalid` = 0; `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` = 0
- Grant latency: 1 cycle. A source whose valid is first seen in ST_IDLE sees its first beat on `m_axis` in the next cycle.
- Data path latency: 0 cycles; the mux is combinational with no added registers.
- Inter-packet gap: exactly 1 idle cycle between consecutive packets.
- A single-beat packet occupies one ST_PKT cycle.
- Mid-packet `tvalid` gaps or output backpressure: the grant stays locked with no timeout. No other source may be granted until `tlast` handshakes.
- Simultaneous requests: strict rotation. With all 4 sources valid continuously, grant order is 0,1,2,3,0,…
- A requester that drops valid while in ST_IDLE before being granted loses nothing; it is re-evaluated on the next cycle.
- Reset asserted mid-packet: return to reset values immediately. The partial packet is truncated, and the downstream tagger must be reset on the same `aresetn`.
- N_SRC = 1: the arbiter degenerates to lock/unlock; the 1-cycle gap per packet is still present.

## Structure
- Shared VIU package holds the route field constants:
  - ROUTE_SRC_NODE_MSB/LSB (13/12)
  - ROUTE_SRC_VFPGA (11:8)
  - ROUTE_DST_NODE (7:6)
  - ROUTE_DST_VFPGA (5:2)
  - ROUTE_W = 14
  - the arb state enum
- The tagger already decodes these same fields; both blocks use the package definitions.
- Sub-module `viu_rr_pick`: combinational round-robin find-first. Inputs are the request vector and `rr_ptr`; outputs are `pick_idx` and `pick_valid`.

## Test plan
- Single request, source 2, `s_dst_route` = 6'b01_0011, 3-beat packet, NODE_ID = 1 -> grant 1 cycle after valid; route_out = 14'b01_0010_01_0011_00; 3 beats pass unmodified, tlast on beat 3; busy falls after tlast.
- All 4 sources valid with back-to-back 2-beat packets -> grant order 0,1,2,3,0; exactly 1 idle cycle between packets; no interleaved beats.
- Source 1 granted; `m_axis_tready` low for 5 cycles mid-packet while source 3 requests -> source 1 stays granted, `s_axis_tready[3]` = 0 throughout, source 3 granted after source 1's tlast.
- Source 0 changes `s_dst_route` from 6'h05 to 6'h3A mid-packet -> route_out keeps dst field 6'h05 until the packet ends.
- `aresetn` low during beat 2 of a 4-beat packet -> next cycle: all outputs at reset values, rr_ptr = N_SRC-1; next grant goes to the lowest valid source.
- Single-beat packets from source 3 only, sent continuously -> one packet every 2 cycles; route[11:8] = 4'd3 regardless of the value source 3 drives.
